// File: rtl/counter_arbiter_pkg.sv
// Shared definitions for counter controllers: FSM encodings and
// round-robin pointer helpers.
package counter_arbiter_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Index that follows pointer p in a ring of n entries.
   function automatic int rr_next(input int p, input int n);
      return (p + 1) % n;
   endfunction

   // Search distance of index i when the search starts just above pointer p.
   function automatic int rr_dist(input int i, input int p, input int n);
      return (i - rr_next(p, n) + n) % n;
   endfunction

endpackage

// File: rtl/counter_arbiter_rr.sv
// Combinational round-robin picker: searches upward from ptr+1 and
// returns the first requester found as one-hot and index.
import counter_arbiter_pkg::*;

module rr_arbiter #(
   parameter int nreq = 4,
   localparam int iw = (nreq > 1) ? $clog2(nreq) : 1
) (
   input  logic [nreq-1:0] req,
   input  logic [iw-1:0]   ptr,
   output logic [nreq-1:0] win,
   output logic [iw-1:0]   idx,
   output logic            any
);

   int best;
   int d;

   always_comb begin
      best = nreq;
      d    = 0;
      idx  = '0;
      win  = '0;
      for (int i = 0; i < nreq; i++) begin
         d = rr_dist(i, int'(ptr), nreq);
         if (req[i] && (d < best)) begin
            best = d;
            idx  = iw'(i);
         end
      end
      any = (best < nreq);
      if (any) win[idx] = 1'b1;
   end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin scheduler sharing one up-counter among nreq timing clients.
//   state   | meaning
//   IDLE    | no grant, cnt=0, arbitrates on every edge
//   RUN     | grant held, cnt counts 0..limit
//   DONE    | one-cycle done pulse, no arbitration
import counter_arbiter_pkg::*;

module counter_arbiter #(
   parameter int width = 4,
   parameter int nreq  = 4
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic [nreq-1:0]       req,
   input  logic [nreq*width-1:0] len,
   output logic [nreq-1:0]       gnt,
   output logic [width-1:0]      cnt,
   output logic                  busy,
   output logic [nreq-1:0]       done
);

   localparam int iw = (nreq > 1) ? $clog2(nreq) : 1;

   logic [1:0]       state;
   logic [iw-1:0]    ptr;
   logic [width-1:0] limit;
   logic [width-1:0] len_sel;
   logic [nreq-1:0]  win_oh;
   logic [iw-1:0]    win_idx;
   logic             win_any;

   rr_arbiter #(.nreq(nreq)) u_arb (
      .req (req),
      .ptr (ptr),
      .win (win_oh),
      .idx (win_idx),
      .any (win_any)
   );

   always_comb begin
      len_sel = '0;
      for (int i = 0; i < nreq; i++) begin
         if (win_idx == iw'(i)) len_sel = len[i*width +: width];
      end
   end

   // gnt is one-hot on the owner during RUN, so it doubles as the owner select.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state <= ST_IDLE;
         ptr   <= iw'(nreq - 1);
         limit <= '0;
         cnt   <= '0;
         gnt   <= '0;
         busy  <= 1'b0;
         done  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt  <= '0;
               done <= '0;
               if (win_any) begin
                  gnt   <= win_oh;
                  limit <= len_sel;
                  ptr   <= win_idx;
                  busy  <= 1'b1;
                  state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if ((req & gnt) == '0) begin
                  gnt   <= '0;
                  cnt   <= '0;
                  busy  <= 1'b0;
                  state <= ST_IDLE;
               end else if (cnt == limit) begin
                  done  <= gnt;
                  gnt   <= '0;
                  state <= ST_DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               done  <= '0;
               cnt   <= '0;
               gnt   <= '0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_counter_arbiter.sv
// Directed plus randomized bench for counter_arbiter against a
// transaction-level reference model.
module tb_counter_arbiter;

   localparam int W = 4;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rstn = 1'b0;
   logic [N-1:0]   req = '0;
   logic [N*W-1:0] len = '0;
   logic [N-1:0]   gnt;
   logic [W-1:0]   cnt;
   logic           busy;
   logic [N-1:0]   done;

   counter_arbiter #(.width(W), .nreq(N)) dut (
      .clk  (clk),
      .rstn (rstn),
      .req  (req),
      .len  (len),
      .gnt  (gnt),
      .cnt  (cnt),
      .busy (busy),
      .done (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // reference model: who owns the counter, how far it has run, pending done
   int m_owner, m_ptr, m_lim, m_cnt, m_done_who;
   bit m_indone;

   function automatic void model_reset();
      m_owner = -1; m_ptr = N - 1; m_lim = 0; m_cnt = 0;
      m_done_who = -1; m_indone = 1'b0;
   endfunction

   function automatic void model_edge();
      if (m_indone) begin
         m_indone = 1'b0; m_done_who = -1; m_cnt = 0;
      end else if (m_owner < 0) begin
         for (int k = 1; k <= N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (req[c] && m_owner < 0) begin
               m_owner = c; m_ptr = c; m_cnt = 0;
               m_lim = int'(len[c*W +: W]);
            end
         end
      end else if (!req[m_owner]) begin
         m_owner = -1; m_cnt = 0;
      end else if (m_cnt == m_lim) begin
         m_done_who = m_owner; m_owner = -1; m_indone = 1'b1;
      end else begin
         m_cnt = m_cnt + 1;
      end
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [31:0] eg, ed;
      eg = (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0;
      ed = (m_done_who >= 0) ? (32'd1 << m_done_who) : 32'd0;
      chk({tag, "/gnt"}, 32'(gnt), eg);
      chk({tag, "/cnt"}, 32'(cnt), 32'(m_cnt));
      chk({tag, "/busy"}, 32'(busy), 32'((m_owner >= 0) || m_indone));
      chk({tag, "/done"}, 32'(done), ed);
   endtask

   task automatic step(input string tag);
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_all(tag);
   endtask

   task automatic sync_reset();
      @(negedge clk);
      rstn = 1'b0;
      model_reset();
      @(negedge clk);
      rstn = 1'b1;
   endtask

   initial begin
      int gc, seen, maxc, dcnt;
      int gcyc[$];
      logic [N-1:0] gseq[$];

      model_reset();
      #12;
      check_all("reset");
      @(negedge clk);
      rstn = 1'b1;

      // T1: single request, len 3
      len[3:0] = 4'd3; req = 4'b0001;
      gc = 0; seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step("t1");
         if (gnt == 4'b0001) gc++;
         if (done == 4'b0001) seen = 1;
      end
      chk("t1_done_seen", 32'(seen), 32'd1);
      chk("t1_grant_cycles", 32'(gc), 32'd4);
      req = '0;
      step("t1_after");
      chk("t1_busy_low", 32'(busy), 32'd0);

      // T2: all requesting, zero lengths -> rotating 1-cycle grants
      sync_reset();
      len = '0; req = 4'b1111;
      for (int c = 1; c <= 13; c++) begin
         step("t2");
         if (gnt != '0) begin gseq.push_back(gnt); gcyc.push_back(c); end
      end
      chk("t2_grant_count", 32'(gseq.size()), 32'd5);
      for (int k = 0; k < gseq.size() && k < 5; k++) begin
         chk("t2_order", 32'(gseq[k]), 32'd1 << (k % 4));
         if (k > 0) chk("t2_spacing", 32'(gcyc[k] - gcyc[k-1]), 32'd3);
      end
      req = '0;
      repeat (3) step("t2_drain");

      // T3: max length runs 0..15 without wrap
      len[11:8] = 4'd15; req = 4'b0100;
      gc = 0; seen = 0; maxc = 0;
      for (int i = 0; i < 40 && !seen; i++) begin
         step("t3");
         if (gnt == 4'b0100) begin gc++; if (int'(cnt) > maxc) maxc = int'(cnt); end
         if (done == 4'b0100) seen = 1;
      end
      chk("t3_done_seen", 32'(seen), 32'd1);
      chk("t3_grant_cycles", 32'(gc), 32'd16);
      chk("t3_max_cnt", 32'(maxc), 32'd15);
      req = '0;
      repeat (2) step("t3_drain");

      // T4: abort at cnt 2, next grant goes above index 1
      len[7:4] = 4'd5; req = 4'b0010;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step("t4");
         if (gnt == 4'b0010 && cnt == 4'd2) seen = 1;
      end
      chk("t4_reached_cnt2", 32'(seen), 32'd1);
      req = 4'b1101;
      step("t4_abort");
      chk("t4_abort_gnt", 32'(gnt), 32'd0);
      chk("t4_abort_done", 32'(done), 32'd0);
      step("t4_rearb");
      chk("t4_next_winner", 32'(gnt), 32'b0100);
      req = '0;
      repeat (3) step("t4_drain");

      // T5: asynchronous reset mid-RUN
      len[3:0] = 4'd5; req = 4'b0001;
      seen = 0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step("t5");
         if (gnt == 4'b0001 && cnt == 4'd2) seen = 1;
      end
      chk("t5_reached_cnt2", 32'(seen), 32'd1);
      #2 rstn = 1'b0;
      #1;
      chk("t5_async_gnt", 32'(gnt), 32'd0);
      chk("t5_async_cnt", 32'(cnt), 32'd0);
      chk("t5_async_busy", 32'(busy), 32'd0);
      chk("t5_async_done", 32'(done), 32'd0);
      model_reset();
      @(negedge clk);
      rstn = 1'b1; req = 4'b1111;
      step("t5_post");
      chk("t5_first_winner", 32'(gnt), 32'b0001);
      req = '0;
      repeat (3) step("t5_drain");

      // T6: len changed after grant is ignored
      len[3:0] = 4'd3; req = 4'b0001;
      step("t6_grant");
      len[3:0] = 4'd7;
      seen = 0; dcnt = -1;
      for (int i = 0; i < 20 && !seen; i++) begin
         step("t6");
         if (done == 4'b0001) begin seen = 1; dcnt = int'(cnt); end
      end
      chk("t6_done_seen", 32'(seen), 32'd1);
      chk("t6_term_cnt", 32'(dcnt), 32'd3);
      req = '0;
      repeat (2) step("t6_drain");

      // T7: random traffic, including aborts
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 3) == 0) req = N'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) len = (N*W)'($urandom);
         step("rand");
         chk("rand_excl", 32'(|(gnt & done) | (|done & |gnt)), 32'd0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
